// File: rtl/wb_skid_stage.sv
// Write-back skid stage: two-entry elastic buffer between execute and the
// register file, with forwarding of pending writes and a retire counter.
module wb_skid_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_wd,
   input  logic              in_wreg,
   input  logic [DATA_W-1:0] in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_wd,
   output logic              out_wreg,
   output logic [DATA_W-1:0] out_wdata,
   input  logic [ADDR_W-1:0] fwd_raddr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              main_v_q, main_v_d;
   logic [ADDR_W-1:0] main_wd_q, main_wd_d;
   logic              main_wreg_q, main_wreg_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic              skid_v_q, skid_v_d;
   logic [ADDR_W-1:0] skid_wd_q, skid_wd_d;
   logic              skid_wreg_q, skid_wreg_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic accept;
   logic pop;
   logic in_wreg_m;
   logic skid_hit;
   logic main_hit;

   assign in_ready  = !rst && !skid_v_q;
   assign accept    = in_valid && in_ready;
   assign pop       = main_v_q && out_ready;
   // Writes to x0 are architecturally void, so drop them on entry.
   assign in_wreg_m = in_wreg && (in_wd != '0);

   assign out_valid  = main_v_q;
   assign out_wd     = main_wd_q;
   assign out_wreg   = main_v_q && main_wreg_q;
   assign out_wdata  = main_data_q;
   assign retire_cnt = cnt_q;

   assign skid_hit = (fwd_raddr != '0) && skid_v_q && skid_wreg_q
                     && (skid_wd_q == fwd_raddr);
   assign main_hit = (fwd_raddr != '0) && main_v_q && main_wreg_q
                     && (main_wd_q == fwd_raddr);

   always_comb begin
      fwd_hit  = skid_hit || main_hit;
      fwd_data = '0;
      if (skid_hit) begin
         fwd_data = skid_data_q;
      end else if (main_hit) begin
         fwd_data = main_data_q;
      end
   end

   always_comb begin
      main_v_d    = main_v_q;
      main_wd_d   = main_wd_q;
      main_wreg_d = main_wreg_q;
      main_data_d = main_data_q;
      skid_v_d    = skid_v_q;
      skid_wd_d   = skid_wd_q;
      skid_wreg_d = skid_wreg_q;
      skid_data_d = skid_data_q;
      cnt_d       = cnt_q;

      if (pop && main_wreg_q) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (flush) begin
         main_v_d    = 1'b0;
         main_wreg_d = 1'b0;
         skid_v_d    = 1'b0;
         skid_wreg_d = 1'b0;
      end else if (!main_v_q || pop) begin
         if (skid_v_q) begin
            main_v_d    = 1'b1;
            main_wd_d   = skid_wd_q;
            main_wreg_d = skid_wreg_q;
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
            skid_wreg_d = 1'b0;
         end else if (accept) begin
            main_v_d    = 1'b1;
            main_wd_d   = in_wd;
            main_wreg_d = in_wreg_m;
            main_data_d = in_wdata;
         end else begin
            main_v_d    = 1'b0;
            main_wreg_d = 1'b0;
         end
      end else if (accept) begin
         // Main is stalled: park the newcomer behind it.
         skid_v_d    = 1'b1;
         skid_wd_d   = in_wd;
         skid_wreg_d = in_wreg_m;
         skid_data_d = in_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_v_q    <= 1'b0;
         main_wd_q   <= '0;
         main_wreg_q <= 1'b0;
         main_data_q <= '0;
         skid_v_q    <= 1'b0;
         skid_wd_q   <= '0;
         skid_wreg_q <= 1'b0;
         skid_data_q <= '0;
         cnt_q       <= '0;
      end else begin
         main_v_q    <= main_v_d;
         main_wd_q   <= main_wd_d;
         main_wreg_q <= main_wreg_d;
         main_data_q <= main_data_d;
         skid_v_q    <= skid_v_d;
         skid_wd_q   <= skid_wd_d;
         skid_wreg_q <= skid_wreg_d;
         skid_data_q <= skid_data_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_skid_stage.sv
// Scoreboard bench for wb_skid_stage: the model is an ordered queue of
// pending writes; the monitor checks the DUT against its head and contents.
module tb_wb_skid_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   typedef struct {
      logic [AW-1:0] wd;
      logic          wreg;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_wd;
   logic          in_wreg;
   logic [DW-1:0] in_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_wd;
   logic          out_wreg;
   logic [DW-1:0] out_wdata;
   logic [AW-1:0] fwd_raddr;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic [CW-1:0] retire_cnt;

   wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
      .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   ent_t          q[$];
   logic [CW-1:0] m_cnt = '0;
   int            checks = 0;
   int            errors = 0;
   logic          mon_en = 1'b0;
   logic          rst_seen = 1'b0;

   // Inputs driven in the previous cycle take effect at the next edge.
   logic p_acc = 1'b0;
   logic p_fl  = 1'b0;
   logic p_rst = 1'b1;
   ent_t p_ent;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] wd,
                        input logic wr, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input logic r,
                        input logic [AW-1:0] ra);
      @(posedge clk);
      #1;
      if (p_rst || p_fl) begin
         q.delete();
      end else if (p_acc) begin
         q.push_back(p_ent);
      end
      mon_en    = 1'b1;
      rst       = r;
      flush     = fl;
      in_valid  = v;
      in_wd     = wd;
      in_wreg   = wr;
      in_wdata  = d;
      out_ready = ordy;
      fwd_raddr = ra;
      p_acc     = v && !r && (q.size() < 2);
      p_fl      = fl;
      p_rst     = r;
      p_ent.wd   = wd;
      p_ent.wreg = wr && (wd != 0);
      p_ent.data = d;
   endtask

   task automatic idle(input logic ordy, input logic [AW-1:0] ra, input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, ordy, 1'b0, 1'b0, ra);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         logic          eh;
         logic [DW-1:0] ed;
         eh = 1'b0;
         ed = '0;
         for (int i = 0; i < q.size() && i < 2; i++) begin
            if (fwd_raddr != 0 && q[i].wreg && q[i].wd == fwd_raddr) begin
               eh = 1'b1;
               ed = q[i].data;
            end
         end
         chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
         chk("in_ready", DW'(in_ready), DW'(!rst && q.size() < 2));
         chk("retire_cnt", DW'(retire_cnt), DW'(m_cnt));
         chk("fwd_hit", DW'(fwd_hit), DW'(eh));
         chk("fwd_data", fwd_data, ed);
         if (q.size() > 0) begin
            chk("out_wd", DW'(out_wd), DW'(q[0].wd));
            chk("out_wreg", DW'(out_wreg), DW'(q[0].wreg));
            chk("out_wdata", out_wdata, q[0].data);
         end else begin
            chk("out_wreg_idle", DW'(out_wreg), '0);
         end
         if (rst_seen) begin
            chk("rst_out_wd", DW'(out_wd), '0);
            chk("rst_out_wdata", out_wdata, '0);
         end
         if (rst) begin
            m_cnt = '0;
         end else if (out_ready && q.size() > 0) begin
            if (q[0].wreg) m_cnt = m_cnt + 1'b1;
            void'(q.pop_front());
         end
         rst_seen = rst;
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wd = '0; in_wreg = 1'b0;
      in_wdata = '0; out_ready = 1'b0; fwd_raddr = '0;
      p_ent.wd = '0; p_ent.wreg = 1'b0; p_ent.data = '0;
      drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, '0);
      idle(1'b1, 5'd3, 2);

      // Streaming single write.
      drive(1'b1, 5'd3, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 5'd3);
      idle(1'b1, 5'd3, 3);

      // Stall fills main then skid; a third offer is refused.
      drive(1'b1, 5'd1, 1'b1, 32'h0000_00A1, 1'b0, 1'b0, 1'b0, 5'd1);
      drive(1'b1, 5'd2, 1'b1, 32'h0000_00B2, 1'b0, 1'b0, 1'b0, 5'd2);
      drive(1'b1, 5'd7, 1'b1, 32'h0000_00C7, 1'b0, 1'b0, 1'b0, 5'd2);
      drive(1'b1, 5'd7, 1'b1, 32'h0000_00C7, 1'b0, 1'b0, 1'b0, 5'd7);
      idle(1'b1, 5'd1, 4);

      // Write to x0 is suppressed and never forwarded.
      drive(1'b1, 5'd0, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 5'd0);
      idle(1'b1, 5'd0, 2);

      // Skid wins over main for the same register.
      drive(1'b1, 5'd5, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 5'd5);
      drive(1'b1, 5'd5, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 5'd5);
      idle(1'b0, 5'd5, 2);
      idle(1'b1, 5'd5, 3);

      // Flush with both entries full and a concurrent offer.
      drive(1'b1, 5'd8, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 5'd9);
      drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 5'd9);
      drive(1'b1, 5'd9, 1'b1, 32'hEE, 1'b0, 1'b0, 1'b0, 5'd9);
      drive(1'b1, 5'd9, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 5'd9);
      idle(1'b1, 5'd9, 3);

      // Sixteen retired writes wrap a 4-bit counter.
      for (int i = 0; i < 16; i++)
         drive(1'b1, AW'(i % 31 + 1), 1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 5'd1);
      idle(1'b1, 5'd1, 3);

      // Reset while stalled with both entries held.
      drive(1'b1, 5'd4, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 5'd4);
      drive(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 5'd4);
      drive(1'b1, 5'd6, 1'b1, 32'h67, 1'b1, 1'b0, 1'b1, 5'd4);
      idle(1'b1, 5'd4, 3);

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) != 0, AW'($urandom % 8), 1'($urandom),
               $urandom, ($urandom % 3) != 0, ($urandom % 60) == 0,
               ($urandom % 300) == 0, AW'($urandom % 8));
      end
      idle(1'b1, 5'd0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_skid_stage.md
WB_SKID_STAGE -- requirements
Module: wb_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter CNT_W, default 32, meaning retire-counter width.
REQ-004 SHALL have ports:
- clk  input  1  clock; one clock, all state on rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discard all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept.
- in_wd  input  ADDR_W  destination register.
- in_wreg  input  1  write enable.
- in_wdata  input  DATA_W  write data.
- out_valid  output  1  entry presented to write-back.
- out_ready  input  1  write-back consumes entry.
- out_wd  output  ADDR_W  destination register.
- out_wreg  output  1  write enable.
- out_wdata  output  DATA_W  write data.
- fwd_raddr  input  ADDR_W  forwarding query address.
- fwd_hit  output  1  query matches a held write.
- fwd_data  output  DATA_W  forwarded data.
- retire_cnt  output  CNT_W  count of retired register writes.

Function
REQ-005 SHALL hold two entries: main (drives out_*) and skid; each has valid, wd, wreg, wdata.
REQ-006 SHALL define accept = in_valid && in_ready, and pop = out_valid && out_ready.
REQ-007 SHALL drive in_ready = !rst && !skid_valid, combinationally from registered state.
REQ-008 SHALL, on accept with in_wd == 0, store wreg = 0 (x0 writes suppressed); wd and wdata stored unchanged.
REQ-009 SHALL, when main empty or pop: load main from skid if skid valid (skid then empty), else from input if accept, else main becomes empty.
REQ-010 SHALL, when main valid and !out_ready and accept: load skid from input; main unchanged.
REQ-011 SHALL keep out_wd, out_wreg, out_wdata stable while out_valid && !out_ready.
REQ-012 SHALL give latency one cycle: entry accepted at edge N appears on out_* after edge N when main empty or popped.
REQ-013 SHALL drive out_wreg = 0 whenever out_valid = 0.
REQ-014 SHALL, on flush, clear both valid bits and wreg bits at the next edge; an input accepted in the same cycle is dropped; pop in the same cycle still counts as retired.
REQ-015 SHALL compute fwd_hit combinationally: fwd_raddr != 0 and a valid entry with wreg = 1 and wd == fwd_raddr; skid (younger) takes priority over main.
REQ-016 SHALL drive fwd_data = wdata of the winning entry, else 0.
REQ-017 SHALL increment retire_cnt by 1 on each pop with out_wreg = 1; it wraps modulo 2^CNT_W; flush does not clear it.
REQ-018 SHALL never lose or duplicate an entry; order is preserved (main before skid).

Reset
REQ-019 SHALL, while rst = 1 at a clock edge, clear both entries (valid, wd, wreg, wdata = 0) and retire_cnt = 0.
REQ-020 SHALL have, after reset: out_valid = 0, out_wd = 0, out_wreg = 0, out_wdata = 0, fwd_hit = 0, fwd_data = 0, in_ready = 1.
REQ-021 SHALL give rst priority over flush, accept and pop; reset mid-stall discards held entries without counting.

Verification
REQ-022 Stream: in (wd=3, wreg=1, data=0xAAAA5555) with out_ready=1 -> next cycle out_valid=1, out_wd=3, out_wdata=0xAAAA5555; retire_cnt=1 after pop.
REQ-023 Stall: out_ready=0, push A(wd=1), B(wd=2) -> main=A, skid=B, in_ready=0; out_ready=1 -> A then B on consecutive cycles, in_ready=1 again.
REQ-024 x0: push wd=0, wreg=1, data=0x1234 -> out_wreg=0; retire_cnt unchanged after pop; fwd_raddr=0 -> fwd_hit=0.
REQ-025 Forward priority: main wd=5 data=0x11, skid wd=5 data=0x22, fwd_raddr=5 -> fwd_hit=1, fwd_data=0x22.
REQ-026 Flush with both entries full plus concurrent in_valid -> next cycle out_valid=0, in_ready=1, fwd_hit=0, input not presented.
REQ-027 Counter wrap with CNT_W=4: 16 retired writes -> retire_cnt=0; rst=1 during stall -> all outputs reset per REQ-020.
